// File: rtl/rf_pkg.sv
// Register file shared definitions: widths, the hard-wired zero
// register and the writeback request bundle.
package rf_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_ZERO_REG = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbq_match.sv
// Address compare across the live queue entries for one read port.
// With WBQ_FWD_EN it also returns the data of the youngest hit.
module wbq_match
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
`ifdef WBQ_FWD_EN
  input  logic [DATA_W-1:0] data_i [DEPTH],
  output logic [DATA_W-1:0] data_o,
`endif
  input  logic [PW-1:0]     rd_ptr_i,
  input  logic [CW-1:0]     count_i,
  input  logic [ADDR_W-1:0] chk_i,
  output logic              hit_o
);

  logic [PW-1:0] idx;
  logic          chk_ok;

  assign chk_ok = chk_i != ADDR_W'(RF_ZERO_REG);

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o  = 1'b0;
    idx    = '0;
`ifdef WBQ_FWD_EN
    data_o = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PW'(k);
      if (CW'(k) < count_i && chk_ok &&
          addr_i[idx] == chk_i) begin
        hit_o  = 1'b1;
`ifdef WBQ_FWD_EN
        data_o = data_i[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue, sole writer of the register file.
// Optional WBQ_FWD_EN adds youngest-hit forwarding data per read port.
module wb_write_queue
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
`ifdef WBQ_FWD_EN
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic              busy1,
  output logic              busy2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              full;
  logic              push;
  logic              pop;
  logic              hs;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign full      = count_q == CW'(DEPTH);
  assign mem_ready = rst && !full;
  assign alu_ready = rst && !full && !mem_valid;

  // Writes to the zero register handshake but never occupy a slot.
  always_comb begin
    push_addr = mem_valid ? mem_addr : alu_addr;
    push_data = mem_valid ? mem_data : alu_data;
    hs        = (mem_valid && mem_ready) ||
                (alu_valid && alu_ready);
    push      = hs && push_addr != ADDR_W'(RF_ZERO_REG);
    pop       = count_q != '0;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= push_addr;
        data_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign rf_we    = pop;
  assign rf_waddr = addr_q[rd_ptr_q];
  assign rf_wdata = data_q[rd_ptr_q];

`ifdef WBQ_FWD_EN
  logic [DATA_W-1:0] hit_data1, hit_data2;
  assign fwd_data1 = busy1 ? hit_data1 : '0;
  assign fwd_data2 = busy2 ? hit_data2 : '0;
`endif

  wbq_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match1 (
    .addr_i   (addr_q),
`ifdef WBQ_FWD_EN
    .data_i   (data_q),
    .data_o   (hit_data1),
`endif
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q),
    .chk_i    (chk_addr1),
    .hit_o    (busy1)
  );

  wbq_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_match2 (
    .addr_i   (addr_q),
`ifdef WBQ_FWD_EN
    .data_i   (data_q),
    .data_o   (hit_data2),
`endif
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q),
    .chk_i    (chk_addr2),
    .hit_o    (busy2)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: vector table plus
// hand-written wrap and asynchronous-reset sequences.
module tb_wb_write_queue;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, mem_valid;
  logic       alu_ready, mem_ready;
  logic [2:0] alu_addr, mem_addr;
  logic [7:0] alu_data, mem_data;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] chk_addr1, chk_addr2;
  logic       busy1, busy2;
`ifdef WBQ_FWD_EN
  logic [7:0] fwd_data1, fwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_queue dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
`ifdef WBQ_FWD_EN
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
`endif
    .busy1     (busy1),
    .busy2     (busy2)
  );

  typedef struct {
    logic    av;
    wb_req_t a;
    logic    mv;
    wb_req_t m;
    logic [2:0] c1, c2;
    logic    e_ar, e_mr, e_we;
    wb_req_t e_rf;
    logic    e_b1, e_b2;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(
    input logic av, input logic [2:0] aa,
    input logic [7:0] ad,
    input logic mv, input logic [2:0] ma,
    input logic [7:0] md,
    input logic [2:0] c1, input logic [2:0] c2,
    input logic ar, input logic mr, input logic we,
    input logic [2:0] wa, input logic [7:0] wd,
    input logic b1, input logic b2);
    vec_t v;
    v.av = av; v.a.addr = aa; v.a.data = ad;
    v.mv = mv; v.m.addr = ma; v.m.data = md;
    v.c1 = c1; v.c2 = c2;
    v.e_ar = ar; v.e_mr = mr; v.e_we = we;
    v.e_rf.addr = wa; v.e_rf.data = wd;
    v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_addr  = '0;
    mem_data  = '0;
  endtask

  logic [2:0] wa [9];
  logic [7:0] wd [9];

  initial begin
    //   av aa ad    mv ma md    c1 c2 ar mr we wa wd   b1 b2
    vt[0] = mk(0,0,8'h00, 0,0,8'h00, 3,0, 1,1,0, 0,8'h00, 0,0);
    vt[1] = mk(1,3,8'h5A, 0,0,8'h00, 3,0, 1,1,0, 0,8'h00, 0,0);
    vt[2] = mk(0,0,8'h00, 0,0,8'h00, 3,0, 1,1,1, 3,8'h5A, 1,0);
    vt[3] = mk(0,0,8'h00, 0,0,8'h00, 3,0, 1,1,0, 0,8'h00, 0,0);
    vt[4] = mk(1,4,8'h22, 1,2,8'h11, 2,4, 0,1,0, 0,8'h00, 0,0);
    vt[5] = mk(1,4,8'h22, 0,0,8'h00, 2,4, 1,1,1, 2,8'h11, 1,0);
    vt[6] = mk(0,0,8'h00, 0,0,8'h00, 2,4, 1,1,1, 4,8'h22, 0,1);
    vt[7] = mk(0,0,8'h00, 0,0,8'h00, 2,4, 1,1,0, 0,8'h00, 0,0);
    vt[8] = mk(1,0,8'hFF, 0,0,8'h00, 0,0, 1,1,0, 0,8'h00, 0,0);
    vt[9] = mk(0,0,8'h00, 0,0,8'h00, 0,0, 1,1,0, 0,8'h00, 0,0);

    for (int i = 0; i < 9; i++) begin
      wa[i] = (i < 7) ? 3'(i + 1) : 3'(i - 6);
      wd[i] = 8'(8'h30 + i);
    end

    idle();
    chk_addr1 = '0;
    chk_addr2 = '0;
    rst = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      alu_valid = vt[i].av;
      alu_addr  = vt[i].a.addr;
      alu_data  = vt[i].a.data;
      mem_valid = vt[i].mv;
      mem_addr  = vt[i].m.addr;
      mem_data  = vt[i].m.data;
      chk_addr1 = vt[i].c1;
      chk_addr2 = vt[i].c2;
      #3;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vt[i].e_ar);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, vt[i].e_mr);
      chk($sformatf("v%0d_rf_we", i), rf_we, vt[i].e_we);
      chk($sformatf("v%0d_rf_waddr", i), rf_waddr, vt[i].e_rf.addr);
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vt[i].e_rf.data);
      chk($sformatf("v%0d_busy1", i), busy1, vt[i].e_b1);
      chk($sformatf("v%0d_busy2", i), busy2, vt[i].e_b2);
`ifdef WBQ_FWD_EN
      chk($sformatf("v%0d_fwd1", i), fwd_data1,
          vt[i].e_b1 ? vt[i].e_rf.data : 8'h00);
`endif
      @(posedge clk);
      #1;
    end

    // Back-to-back writes wrap both pointers twice.
    idle();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        alu_valid = 1'b1;
        alu_addr  = wa[i];
        alu_data  = wd[i];
      end else begin
        idle();
      end
      chk_addr1 = (i > 0) ? wa[i-1] : 3'd0;
      #3;
      chk($sformatf("wrap%0d_alu_ready", i), alu_ready, 1);
      if (i > 0) begin
        chk($sformatf("wrap%0d_we", i), rf_we, 1);
        chk($sformatf("wrap%0d_waddr", i), rf_waddr, wa[i-1]);
        chk($sformatf("wrap%0d_wdata", i), rf_wdata, wd[i-1]);
        chk($sformatf("wrap%0d_busy1", i), busy1, 1);
      end
      @(posedge clk);
      #1;
    end
    #3;
    chk("wrap_end_we", rf_we, 0);

    // Asynchronous reset with one write pending.
    @(posedge clk);
    #1;
    alu_valid = 1'b1;
    alu_addr  = 3'd5;
    alu_data  = 8'h77;
    chk_addr1 = 3'd5;
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("ar_pending_we", rf_we, 1);
    chk("ar_pending_busy", busy1, 1);
    rst = 1'b0;
    #1;
    chk("ar_we_drop", rf_we, 0);
    chk("ar_busy_drop", busy1, 0);
    chk("ar_alu_ready", alu_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("ar_post%0d_we", i), rf_we, 0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
